// File: rtl/nor_logic_pipe.sv
// Two-stage valid/ready logic unit whose datapath is built purely from 2-input NOR gates.
// Define NOR_LOGIC_PIPE_CNT_EN to add the 16-bit op_count output (completed results, wrapping).

module nor_gate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a | b);
endmodule

module nor_logic_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef NOR_LOGIC_PIPE_CNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [2:0] {
    OP_NOR  = 3'b000,
    OP_OR   = 3'b001,
    OP_AND  = 3'b010,
    OP_NAND = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_BUFA = 3'b111
  } op_e;

  // Stage 1 NOR intermediates (combinational, then registered)
  logic [WIDTH-1:0] n_ab_c, n_a_c, n_b_c, n_aw_c, n_bw_c;

  nor_gate #(.WIDTH(WIDTH)) u_n_ab (.a(a),      .b(b),      .y(n_ab_c));
  nor_gate #(.WIDTH(WIDTH)) u_n_a  (.a(a),      .b(a),      .y(n_a_c));
  nor_gate #(.WIDTH(WIDTH)) u_n_b  (.a(b),      .b(b),      .y(n_b_c));
  nor_gate #(.WIDTH(WIDTH)) u_n_aw (.a(a),      .b(n_ab_c), .y(n_aw_c));
  nor_gate #(.WIDTH(WIDTH)) u_n_bw (.a(n_ab_c), .b(b),      .y(n_bw_c));

  logic [WIDTH-1:0] s1_n_ab, s1_n_a, s1_n_b, s1_n_aw, s1_n_bw;
  op_e              s1_op;
  logic             s1_valid;
  logic             s2_advance;

  // Output stage can take a new beat when it is empty or being drained this cycle.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  // Stage 2 functions derived from the registered intermediates
  logic [WIDTH-1:0] f_or, f_and, f_nand, f_xnor, f_xor, f_buf;

  nor_gate #(.WIDTH(WIDTH)) u_f_or   (.a(s1_n_ab), .b(s1_n_ab), .y(f_or));
  nor_gate #(.WIDTH(WIDTH)) u_f_and  (.a(s1_n_a),  .b(s1_n_b),  .y(f_and));
  nor_gate #(.WIDTH(WIDTH)) u_f_nand (.a(f_and),   .b(f_and),   .y(f_nand));
  nor_gate #(.WIDTH(WIDTH)) u_f_xnor (.a(s1_n_aw), .b(s1_n_bw), .y(f_xnor));
  nor_gate #(.WIDTH(WIDTH)) u_f_xor  (.a(f_xnor),  .b(f_xnor),  .y(f_xor));
  nor_gate #(.WIDTH(WIDTH)) u_f_buf  (.a(s1_n_a),  .b(s1_n_a),  .y(f_buf));

  logic [WIDTH-1:0] y_next;

  // NOTE: assign a default before the case so no path leaves y_next unassigned (no latch).
  always_comb begin
    y_next = s1_n_ab;
    case (s1_op)
      OP_NOR:  y_next = s1_n_ab;
      OP_OR:   y_next = f_or;
      OP_AND:  y_next = f_and;
      OP_NAND: y_next = f_nand;
      OP_XOR:  y_next = f_xor;
      OP_XNOR: y_next = f_xnor;
      OP_NOTA: y_next = s1_n_a;
      OP_BUFA: y_next = f_buf;
      default: y_next = s1_n_ab;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (s2_advance)
        out_valid <= s1_valid;
      if (s2_advance && s1_valid)
        y <= y_next;
    end
  end

  // NOTE: stage 1 payload has no reset; it is only observed when s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_n_ab <= n_ab_c;
      s1_n_a  <= n_a_c;
      s1_n_b  <= n_b_c;
      s1_n_aw <= n_aw_c;
      s1_n_bw <= n_bw_c;
      s1_op   <= op_e'(op);
    end
  end

`ifdef NOR_LOGIC_PIPE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      op_count <= 16'd0;
    else if (out_valid && out_ready)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_nor_logic_pipe.sv
// Self-checking bench for nor_logic_pipe: WIDTH 8, 1 and 64 instances run in lockstep against a
// queue-based transaction model; op_count checks appear when NOR_LOGIC_PIPE_CNT_EN is defined.

module tb_nor_logic_pipe;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;
  logic [2:0]  op = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir8, ir1, ir64;
  logic        ov8, ov1, ov64;
  logic [7:0]  y8;
  logic [0:0]  y1;
  logic [63:0] y64;
`ifdef NOR_LOGIC_PIPE_CNT_EN
  logic [15:0] cnt8, cnt1, cnt64;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    n_pops = 0;
  int    exp_cnt = 0;
  logic  chk_lat = 1'b0;
  logic  pushed, popped, last_ir;
  logic [7:0] last_y8;
  beat_t q[$];

  always #5 clk = ~clk;

  nor_logic_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a_in[7:0]), .b(b_in[7:0]), .op(op),
    .in_valid(in_valid), .in_ready(ir8), .y(y8), .out_valid(ov8), .out_ready(out_ready)
`ifdef NOR_LOGIC_PIPE_CNT_EN
    , .op_count(cnt8)
`endif
  );

  nor_logic_pipe #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a_in[0:0]), .b(b_in[0:0]), .op(op),
    .in_valid(in_valid), .in_ready(ir1), .y(y1), .out_valid(ov1), .out_ready(out_ready)
`ifdef NOR_LOGIC_PIPE_CNT_EN
    , .op_count(cnt1)
`endif
  );

  nor_logic_pipe #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .a(a_in), .b(b_in), .op(op),
    .in_valid(in_valid), .in_ready(ir64), .y(y64), .out_valid(ov64), .out_ready(out_ready)
`ifdef NOR_LOGIC_PIPE_CNT_EN
    , .op_count(cnt64)
`endif
  );

  function automatic logic [63:0] ref_fn(input logic [2:0] o, input logic [63:0] x, input logic [63:0] w);
    case (o)
      3'd0:    return ~(x | w);
      3'd1:    return x | w;
      3'd2:    return x & w;
      3'd3:    return ~(x & w);
      3'd4:    return x ^ w;
      3'd5:    return ~(x ^ w);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: drive inputs at negedge, sample, update the model.
  task automatic step(input logic v, input logic [63:0] aa, input logic [63:0] bb,
                      input logic [2:0] oo, input logic ordy);
    beat_t       h;
    logic [63:0] r;
    logic        exp_ir;
    @(negedge clk);
    in_valid = v; a_in = aa; b_in = bb; op = oo; out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    checks++;
    if (ir8 !== exp_ir || ir1 !== exp_ir || ir64 !== exp_ir) begin
      errors++;
      $display("FAIL in_ready cyc=%0d got %b/%b/%b expected %b", cyc, ir8, ir1, ir64, exp_ir);
    end
    last_ir = ir8;
    pushed  = v && ir8;
    popped  = ov8 && ordy;
    if (popped) begin
      n_pops++;
      exp_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got y=%h expected no output", cyc, y8);
      end else begin
        h = q.pop_front();
        r = ref_fn(h.op, h.a, h.b);
        if (y8 !== r[7:0]) begin
          errors++;
          $display("FAIL y_w8 cyc=%0d op=%0d got %h expected %h", cyc, h.op, y8, r[7:0]);
        end
        checks++;
        if ({ov1, y1} !== {1'b1, r[0]}) begin
          errors++;
          $display("FAIL y_w1 cyc=%0d op=%0d got v=%b y=%b expected v=1 y=%b", cyc, h.op, ov1, y1, r[0]);
        end
        checks++;
        if ({ov64, y64} !== {1'b1, r}) begin
          errors++;
          $display("FAIL y_w64 cyc=%0d op=%0d got v=%b y=%h expected v=1 y=%h", cyc, h.op, ov64, y64, r);
        end
        if (chk_lat) begin
          checks++;
          if (cyc != h.cyc + 2) begin
            errors++;
            $display("FAIL latency got %0d cycles expected 2", cyc - h.cyc);
          end
        end
        last_y8 = y8;
      end
    end
    if (pushed) q.push_back('{a: aa, b: bb, op: oo, cyc: cyc});
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(1'b0, '0, '0, 3'd0, 1'b1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d beats outstanding expected 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ov8, ov1, ov64} !== 3'b000 || y8 !== 8'h00 || y64 !== 64'h0 || y1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b%b%b y8=%h y64=%h expected ov=000 y=0", ov8, ov1, ov64, y8, y64);
    end
`ifdef NOR_LOGIC_PIPE_CNT_EN
    checks++;
    if (cnt8 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_op_count got %h expected 0000", cnt8);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_after_reset got %b expected 1", ir8);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_tbl[8] = '{8'h18, 8'hE7, 8'h81, 8'h7E, 8'h66, 8'h99, 8'h3C, 8'hC3};
    logic [7:0] got[8];
    int         k = 0;
    chk_lat = 1'b1;
    for (int s = 0; s < 14; s++) begin
      step(s < 8, {rand64() & 64'hFFFF_FFFF_FFFF_FF00} | 64'hC3,
           {rand64() & 64'hFFFF_FFFF_FFFF_FF00} | 64'hA5, 3'(s), 1'b1);
      if (popped && k < 8) begin
        got[k] = last_y8;
        k++;
      end
    end
    chk_lat = 1'b0;
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL all_ops_count got %0d results expected 8", k);
    end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (got[i] !== exp_tbl[i]) begin
        errors++;
        $display("FAIL all_ops_op%0d got %h expected %h", i, got[i], exp_tbl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ba[3], bb[3];
    logic [2:0]  bo[3];
    logic [7:0]  held = '0;
    int          idx = 0;
    int          base = n_pops;
    for (int i = 0; i < 3; i++) begin
      ba[i] = rand64(); bb[i] = rand64(); bo[i] = 3'($urandom_range(0, 7));
    end
    for (int c = 0; c < 16; c++) begin
      step(idx < 3, ba[idx % 3], bb[idx % 3], bo[idx % 3], c >= 7);
      if (pushed) idx++;
      if (c == 2) held = y8;
      if (c >= 2 && c < 7) begin
        checks++;
        if (last_ir !== 1'b0 || ov8 !== 1'b1 || y8 !== held) begin
          errors++;
          $display("FAIL stall_hold c=%0d got ir=%b ov=%b y=%h expected ir=0 ov=1 y=%h", c, last_ir, ov8, y8, held);
        end
      end
    end
    checks++;
    if (n_pops - base != 3) begin
      errors++;
      $display("FAIL stall_results got %0d expected 3", n_pops - base);
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    step(1'b1, rand64(), rand64(), 3'($urandom_range(0, 7)), 1'b1);
    step(1'b1, rand64(), rand64(), 3'($urandom_range(0, 7)), 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a_in = rand64(); b_in = rand64();
    @(posedge clk);
    #1;
    q.delete();
    exp_cnt = 0;
    checks++;
    if (ov8 !== 1'b0 || y8 !== 8'h00 || y64 !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid got ov=%b y8=%h y64=%h expected ov=0 y=0", ov8, y8, y64);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    base = n_pops;
    for (int i = 0; i < 5; i++)
      step(1'b0, '0, '0, 3'd0, 1'b1);
    checks++;
    if (n_pops != base) begin
      errors++;
      $display("FAIL reset_stale got %0d results expected 0", n_pops - base);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand64(), rand64(), 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0);
    drain();
`ifdef NOR_LOGIC_PIPE_CNT_EN
    checks++;
    if (cnt8 !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL op_count got %h expected %h", cnt8, 16'(exp_cnt));
    end
`endif
  endtask

`ifdef NOR_LOGIC_PIPE_CNT_EN
  task automatic test_count_wrap();
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 65537; i++)
      step(1'b1, rand64(), rand64(), 3'($urandom_range(0, 7)), 1'b1);
    drain();
    checks++;
    if (cnt8 !== 16'h0001 || cnt64 !== 16'h0001) begin
      errors++;
      $display("FAIL count_wrap got %h/%h expected 0001", cnt8, cnt64);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ops();
    test_backpressure();
    test_reset_midstream();
    test_random();
`ifdef NOR_LOGIC_PIPE_CNT_EN
    test_count_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
